// File: rtl/fighter_pkg.sv
// Shared constants for the fighter video path: sprite geometry, colour format and
// the blood-animation sequencer state encoding.
package fighter_pkg;

   localparam int SPR_SIZE = 64;
   localparam int SPR_AW   = $clog2(SPR_SIZE);
   localparam int PIX_W    = 10;
   localparam int COLOR_W  = 12;

   localparam logic [COLOR_W-1:0] COLOR_TRANSPARENT = 12'h000;

   // Two-state sequencer; kept as plain constants so older tools accept it.
   localparam int          ST_W    = 1;
   localparam logic [0:0]  ST_IDLE = 1'b0;
   localparam logic [0:0]  ST_PLAY = 1'b1;

endpackage

// File: rtl/blood_anim_ctrl.sv
// Blood-splatter animation sequencer: steps through the frame ROMs on frame_tick,
// addresses the selected ROM from the pixel position and realigns the draw flag.
module blood_anim_ctrl
   import fighter_pkg::*;
#(
   parameter int NUM_FRAMES  = 20,
   parameter int FRAME_TICKS = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          trigger,
   input  logic [PIX_W-1:0]              hit_x,
   input  logic [PIX_W-1:0]              hit_y,
   input  logic                          frame_tick,
   input  logic                          video_on,
   input  logic [PIX_W-1:0]              pix_x,
   input  logic [PIX_W-1:0]              pix_y,
   input  logic [COLOR_W-1:0]            rom_color,
   output logic [$clog2(NUM_FRAMES)-1:0] frame_sel,
   output logic [SPR_AW-1:0]             rom_row,
   output logic [SPR_AW-1:0]             rom_col,
   output logic [COLOR_W-1:0]            blood_rgb,
   output logic                          blood_on,
   output logic                          busy,
   output logic [ST_W-1:0]               dbg_state
);

   localparam int FS_W   = $clog2(NUM_FRAMES);
   localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
   localparam int DW     = PIX_W + 1;

   localparam logic [FS_W-1:0]   LAST_FRAME = FS_W'(NUM_FRAMES - 1);
   localparam logic [TICK_W-1:0] LAST_TICK  = TICK_W'(FRAME_TICKS - 1);
   localparam logic [DW-1:0]     SPR_LIMIT  = DW'(SPR_SIZE);

   logic [ST_W-1:0]   r_state;
   logic [FS_W-1:0]   r_frame_sel;
   logic [TICK_W-1:0] r_tick_cnt;
   logic [PIX_W-1:0]  r_pos_x;
   logic [PIX_W-1:0]  r_pos_y;
   logic              r_in_box_d;

   logic [DW-1:0]     w_dx;
   logic [DW-1:0]     w_dy;
   logic              w_busy;
   logic              w_in_box;
   logic              w_blood_on;

   assign w_busy = (r_state == ST_PLAY);

   // Trigger has priority over frame_tick, including on the final-frame tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_frame_sel <= '0;
         r_tick_cnt  <= '0;
         r_pos_x     <= '0;
         r_pos_y     <= '0;
      end else if (trigger) begin
         r_state     <= ST_PLAY;
         r_frame_sel <= '0;
         r_tick_cnt  <= '0;
         r_pos_x     <= hit_x;
         r_pos_y     <= hit_y;
      end else if (w_busy && frame_tick) begin
         if (r_tick_cnt == LAST_TICK) begin
            r_tick_cnt <= '0;
            if (r_frame_sel == LAST_FRAME) begin
               r_state     <= ST_IDLE;
               r_frame_sel <= '0;
            end else begin
               r_frame_sel <= r_frame_sel + 1'b1;
            end
         end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
         end
      end
   end

   // One extra bit so a sprite near the right/bottom edge never wraps into the box.
   assign w_dx = {1'b0, pix_x} - {1'b0, r_pos_x};
   assign w_dy = {1'b0, pix_y} - {1'b0, r_pos_y};

   assign w_in_box = video_on & w_busy & ~w_dx[DW-1] & ~w_dy[DW-1]
                   & (w_dx < SPR_LIMIT) & (w_dy < SPR_LIMIT);

   // The ROM registers row/col internally, so the in-box flag is delayed to match.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_box_d <= 1'b0;
      end else begin
         r_in_box_d <= w_in_box;
      end
   end

   assign w_blood_on = r_in_box_d & (rom_color != COLOR_TRANSPARENT);

   assign rom_row   = w_dy[SPR_AW-1:0];
   assign rom_col   = w_dx[SPR_AW-1:0];
   assign frame_sel = r_frame_sel;
   assign blood_on  = w_blood_on;
   assign blood_rgb = w_blood_on ? rom_color : COLOR_TRANSPARENT;
   assign busy      = w_busy;
   assign dbg_state = r_state;

endmodule
